// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared types and helpers for the MEM-stage data memory responder.
//   memr_state_t : responder FSM state encoding (2 bits)
//   MEMR_CNT_W   : width of the latency down-counter (LATENCY up to 15)
//   req_legal()  : legality check for a request
//                  (no ren&wen, word aligned, inside the RAM)
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

    localparam int MEMR_CNT_W = 4;

    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_BUSY = 2'd1,
        MEMR_DONE = 2'd2,
        MEMR_ERR  = 2'd3
    } memr_state_t;

    // aw is the word-address width; the byte address must have every bit
    // above aw+1 clear to land inside the RAM.
    function automatic logic req_legal(input logic        ren,
                                       input logic        wen,
                                       input logic [31:0] addr,
                                       input int unsigned aw);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << (aw + 2);
        return !(ren && wen) && (addr[1:0] == 2'b00) && ((addr & hi_mask) == 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// MEM-stage data memory bus between the CPU datapath (master) and the
// memory responder (slave).
//   mem_ren / mem_wen : read / write request, held while mem_stall=1
//   mem_addr          : byte address (word aligned)
//   mem_dout          : write data from the CPU
//   mem_din           : read data to the CPU
//   mem_stall         : request in progress, freeze the pipeline
//   mem_addr_err      : one-cycle pulse for an illegal request
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_addr_err;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall, mem_addr_err
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall, mem_addr_err
    );
endinterface

// File: rtl/data_mem_responder_ram.sv
// ----------------------------------------------------------------------------
// data_ram_sp
// Single-port synchronous word RAM with registered read data.
//   clk  : clock, rising edge
//   we   : write enable
//   addr : word address
//   din  : write data
//   dout : read data, registered (value at addr on the previous edge)
// Contents are not reset.
// ----------------------------------------------------------------------------
module data_ram_sp #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_dout <= r_mem[addr];
    end

    assign dout = r_dout;
endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Responder for the MEM-stage data memory of the 5-stage MIPS CPU. Serves
// word reads/writes from a single-port RAM after LATENCY cycles and stalls
// the pipeline until the access completes.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : data memory bus (slave side), see data_mem_responder_if
// Parameters: ADDR_WIDTH word-address bits, LATENCY 1..15 cycles.
// ----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    // The accept cycle in IDLE is the first latency cycle, so BUSY only has to
    // cover the remaining LATENCY-1 cycles (counter LATENCY-2 down to 0).
    // With LATENCY=1 the access happens on the accept edge and BUSY is skipped.
    localparam bit ACCEPT_IS_ACCESS = (LATENCY <= 1);
    localparam logic [MEMR_CNT_W-1:0] CNT_LOAD =
        (LATENCY >= 2) ? MEMR_CNT_W'(LATENCY - 2) : '0;

    memr_state_t            r_state;
    logic [MEMR_CNT_W-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [31:0]            r_wdata;
    logic                   r_is_wr;
    logic [31:0]            r_din;
    logic                   r_err;

    logic                   w_req;
    logic                   w_legal;
    logic                   w_accept;
    logic                   w_idle;
    logic                   w_ram_we;
    logic [ADDR_WIDTH-1:0]  w_ram_addr;
    logic [31:0]            w_ram_din;
    logic [31:0]            w_ram_dout;

    assign w_req    = bus.mem_ren | bus.mem_wen;
    assign w_legal  = req_legal(bus.mem_ren, bus.mem_wen, bus.mem_addr, ADDR_WIDTH);
    assign w_idle   = (r_state == MEMR_IDLE);
    assign w_accept = w_idle & w_req & w_legal;

    // In IDLE the RAM sees the live request so a LATENCY=1 access can
    // complete on the accept edge; afterwards it sees the latched request,
    // which makes input changes during BUSY irrelevant.
    assign w_ram_addr = w_idle ? bus.mem_addr[ADDR_WIDTH+1:2] : r_addr;
    assign w_ram_din  = w_idle ? bus.mem_dout : r_wdata;
    assign w_ram_we   = (ACCEPT_IS_ACCESS & w_accept & bus.mem_wen)
                      | ((r_state == MEMR_BUSY) & (r_cnt == '0) & r_is_wr);

    data_ram_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (w_ram_din),
        .dout (w_ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MEMR_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_din   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                MEMR_IDLE: begin
                    if (w_req) begin
                        if (w_legal) begin
                            r_addr  <= bus.mem_addr[ADDR_WIDTH+1:2];
                            r_wdata <= bus.mem_dout;
                            r_is_wr <= bus.mem_wen;
                            r_cnt   <= CNT_LOAD;
                            r_state <= ACCEPT_IS_ACCESS ? MEMR_DONE : MEMR_BUSY;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= MEMR_ERR;
                        end
                    end
                end
                MEMR_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= MEMR_DONE;
                    end
                end
                MEMR_DONE: begin
                    // RAM output already holds the read word; keep it for
                    // the cycles after DONE.
                    if (!r_is_wr) begin
                        r_din <= w_ram_dout;
                    end
                    r_state <= MEMR_IDLE;
                end
                MEMR_ERR: begin
                    r_state <= MEMR_IDLE;
                end
                default: begin
                    r_state <= MEMR_IDLE;
                end
            endcase
        end
    end

    // During a read's DONE cycle the fresh word comes straight from the RAM
    // output register; every other cycle shows the held value.
    assign bus.mem_din      = ((r_state == MEMR_DONE) && !r_is_wr) ? w_ram_dout : r_din;
    assign bus.mem_stall    = rst_n & (w_accept | (r_state == MEMR_BUSY));
    assign bus.mem_addr_err = r_err;

endmodule
